// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================
// Package  : dram_arb_pkg
// Purpose  : shared types and defaults for the data-memory arbiter
// Revision : 1.0
// ============================================================
package dram_arb_pkg;

   localparam int DEF_ADDR_W    = 19;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MEM_DEPTH = 262145;

   localparam int C_PORT0 = 0;
   localparam int C_PORT1 = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dram_arb_pick.sv
`default_nettype none
// ============================================================
// Module   : dram_arb_pick
// Purpose  : combinational grant selection (sticky, burst-limited)
// Revision : 1.0
// ============================================================
module dram_arb_pick
   import dram_arb_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 5
) (
   input  logic [1:0]       i_state,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_req0,
   input  logic             i_req1,
   output logic             o_gnt0,
   output logic             o_gnt1
);

   logic w_burst_ok;

   assign w_burst_ok = (32'(i_cnt) < 32'(MAX_BURST));

   always_comb begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
      case (i_state)
         ST_OWN0: begin
            // owner keeps the port until its burst budget is spent and the other side waits
            if (i_req0 && (w_burst_ok || !i_req1)) o_gnt0 = 1'b1;
            else if (i_req1)                       o_gnt1 = 1'b1;
         end
         ST_OWN1: begin
            if (i_req1 && (w_burst_ok || !i_req0)) o_gnt1 = 1'b1;
            else if (i_req0)                       o_gnt0 = 1'b1;
         end
         default: begin
            if (i_req0)      o_gnt0 = 1'b1;
            else if (i_req1) o_gnt1 = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================
// Module   : dram_arbiter
// Purpose  : shares the single-port data memory between core (p0) and loader (p1)
// Revision : 1.0
// ============================================================
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] dAddr,
   output logic [DATA_W-1:0] d_in,
   output logic              MEM_WRITE,
   input  logic [DATA_W-1:0] d_out
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_port_q, rd_port_d;
   logic             rd_oor_q, rd_oor_d;
   logic             err0_q, err0_d;
   logic             err1_q, err1_d;

   logic              w_pick0, w_pick1;
   logic              w_gnt0, w_gnt1, w_any_gnt;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_sel_we;
   logic              w_in_range;
   logic [CNT_W-1:0]  w_cnt_inc;

   dram_arb_pick #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_pick (
      .i_state (state_q),
      .i_cnt   (cnt_q),
      .i_req0  (p0_req),
      .i_req1  (p1_req),
      .o_gnt0  (w_pick0),
      .o_gnt1  (w_pick1)
   );

   assign w_gnt0    = w_pick0 & ~rst;
   assign w_gnt1    = w_pick1 & ~rst;
   assign w_any_gnt = w_gnt0 | w_gnt1;
   assign w_cnt_inc = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      if (w_gnt0) begin
         w_sel_addr  = p0_addr;
         w_sel_wdata = p0_wdata;
         w_sel_we    = p0_we;
      end else if (w_gnt1) begin
         w_sel_addr  = p1_addr;
         w_sel_wdata = p1_wdata;
         w_sel_we    = p1_we;
      end
   end

   assign w_in_range = (64'(w_sel_addr) < 64'(MEM_DEPTH));

   assign p0_ack    = w_gnt0;
   assign p1_ack    = w_gnt1;
   assign dAddr     = w_sel_addr;
   assign d_in      = w_sel_wdata;
   assign MEM_WRITE = w_sel_we & w_in_range;

   always_comb begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      if (w_gnt0) begin
         state_d = ST_OWN0;
         cnt_d   = (state_q == ST_OWN0) ? w_cnt_inc : CNT_W'(1);
      end else if (w_gnt1) begin
         state_d = ST_OWN1;
         cnt_d   = (state_q == ST_OWN1) ? w_cnt_inc : CNT_W'(1);
      end
      rd_pend_d = w_any_gnt & ~w_sel_we;
      rd_port_d = w_gnt1;
      rd_oor_d  = w_any_gnt & ~w_in_range;
      err0_d    = w_gnt0 & ~w_in_range;
      err1_d    = w_gnt1 & ~w_in_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         rd_port_q <= 1'b0;
         rd_oor_q  <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
         rd_oor_q  <= rd_oor_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   // return path is masked during reset so an in-flight read never escapes
   assign p0_rvalid = rd_pend_q & ~rd_port_q & ~rst;
   assign p1_rvalid = rd_pend_q &  rd_port_q & ~rst;
   assign p0_rdata  = (p0_rvalid & ~rd_oor_q) ? d_out : '0;
   assign p1_rdata  = (p1_rvalid & ~rd_oor_q) ? d_out : '0;
   assign p0_err    = err0_q & ~rst;
   assign p1_err    = err1_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : tb_dram_arbiter
// Purpose  : directed scoreboard bench for dram_arbiter (MAX_BURST=4)
// Revision : 1.0
// ============================================================
module tb_dram_arbiter;

   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 262145;
   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
   logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
   logic p0_ack, p0_rvalid, p0_err, p1_ack, p1_rvalid, p1_err, MEM_WRITE;
   logic [DATA_W-1:0] p0_rdata, p1_rdata, d_in;
   logic [DATA_W-1:0] d_out = '0;
   logic [ADDR_W-1:0] dAddr;

   always #5 clk = ~clk;

   dram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .MAX_BURST(MAX_BURST)
   ) u_dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .dAddr(dAddr), .d_in(d_in), .MEM_WRITE(MEM_WRITE), .d_out(d_out)
   );

   // memory model: registered read, read data only refreshes on non-write cycles
   logic [7:0] mem [int];
   always @(posedge clk) begin
      if (MEM_WRITE) mem[int'(dAddr)] = d_in;
      else d_out <= mem.exists(int'(dAddr)) ? mem[int'(dAddr)] : 8'h00;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         port;
      logic       rv;
      logic       err;
      logic [7:0] rd;
      int         due;
   } resp_t;
   resp_t sbq[$];

   always @(negedge clk) begin
      resp_t e;
      if (!rst) begin
         if (p0_rvalid || p1_rvalid || p0_err || p1_err) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_response: got rv=%b%b err=%b%b required none", p0_rvalid, p1_rvalid, p0_err, p1_err);
            end else begin
               e = sbq.pop_front();
               chk("resp_cycle", cyc, e.due);
               chk("p0_rvalid", p0_rvalid, 32'((e.port == 0) ? e.rv : 1'b0));
               chk("p0_err",    p0_err,    32'((e.port == 0) ? e.err : 1'b0));
               chk("p0_rdata",  p0_rdata,  32'((e.port == 0) ? e.rd : 8'h00));
               chk("p1_rvalid", p1_rvalid, 32'((e.port == 1) ? e.rv : 1'b0));
               chk("p1_err",    p1_err,    32'((e.port == 1) ? e.err : 1'b0));
               chk("p1_rdata",  p1_rdata,  32'((e.port == 1) ? e.rd : 8'h00));
            end
         end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_response: port %0d got nothing required rv=%b err=%b", e.port, e.rv, e.err);
         end
         chk("single_grant", 32'(p0_ack & p1_ack), 32'd0);
      end
   end

   int mw_count = 0;
   always @(negedge clk) if (MEM_WRITE) mw_count++;

   bit log_en = 0;
   int glog[$];
   always @(negedge clk) if (log_en) begin
      if (p0_ack) glog.push_back(0);
      if (p1_ack) glog.push_back(1);
   end

   task automatic set_req(input int p, input logic r, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [7:0] wd);
      if (p == 0) begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = wd; end
      else        begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = wd; end
   endtask

   // call at posedge+1; returns at posedge+1 after the ack cycle with req dropped
   task automatic access(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [7:0] wd, input logic exp_rv, input logic exp_err,
                         input logic [7:0] exp_rd, input bit push,
                         output int ack_cyc, output logic mw);
      resp_t r;
      set_req(p, 1'b1, we, a, wd);
      ack_cyc = -1;
      mw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((p == 0) ? p0_ack : p1_ack) begin
            ack_cyc = cyc;
            mw = MEM_WRITE;
            if (push && (exp_rv || exp_err)) begin
               r.port = p; r.rv = exp_rv; r.err = exp_err; r.rd = exp_rd; r.due = cyc + 1;
               sbq.push_back(r);
            end
            break;
         end
      end
      if (ack_cyc < 0) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout: port %0d got no ack required ack within 20 cycles", p);
      end
      @(posedge clk); #1;
      set_req(p, 1'b0, 1'b0, '0, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, mwc;
      logic m0, m1;
      int exp_g[16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};

      // 1: reset with both requests pending
      rst = 1'b1;
      set_req(0, 1'b1, 1'b1, 19'd1, 8'h11);
      set_req(1, 1'b1, 1'b0, 19'd2, 8'h22);
      repeat (3) begin
         @(negedge clk);
         chk("reset_outputs", {25'd0, p0_ack, p1_ack, MEM_WRITE, p0_rvalid, p1_rvalid, p0_err, p1_err}, 32'd0);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, '0, 8'h00);
      set_req(1, 1'b0, 1'b0, '0, 8'h00);
      rst = 1'b0;
      idle(2);

      // 2: write then back-to-back read of addr 5
      mwc = mw_count;
      access(0, 1'b1, 19'd5, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, a0, m0);
      access(0, 1'b0, 19'd5, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, a1, m1);
      chk("t2_write_mw", m0, 1);
      chk("t2_read_mw", m1, 0);
      chk("t2_back_to_back", a1, a0 + 1);
      idle(2);
      chk("t2_mw_once", mw_count - mwc, 1);

      // 3: both streaming, burst-limited alternation
      log_en = 1;
      fork
         for (int i = 0; i < 8; i++) access(0, 1'b1, 19'(100 + i), 8'(i), 1'b0, 1'b0, 8'h00, 1'b1, a0, m0);
         for (int j = 0; j < 8; j++) access(1, 1'b1, 19'(200 + j), 8'(8'h80 + j), 1'b0, 1'b0, 8'h00, 1'b1, a1, m1);
      join
      log_en = 0;
      chk("t3_grant_count", glog.size(), 16);
      for (int i = 0; i < 16; i++) chk($sformatf("t3_grant_%0d", i), (i < glog.size()) ? glog[i] : -1, exp_g[i]);
      idle(1);
      access(0, 1'b0, 19'd103, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, a0, m0);
      access(1, 1'b0, 19'd207, 8'h00, 1'b1, 1'b0, 8'h87, 1'b1, a1, m1);
      idle(2);

      // 4: simultaneous from IDLE; p1 read routed to p1 only
      access(0, 1'b1, 19'd7, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, a0, m0);
      idle(2);
      fork
         access(0, 1'b1, 19'd9, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, a0, m0);
         access(1, 1'b0, 19'd7, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, a1, m1);
      join
      chk("t4_p1_after_p0", a1, a0 + 1);
      idle(2);

      // 5: range boundary
      mem[262200] = 8'hEE;
      access(1, 1'b1, 19'd262145, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, a1, m1);
      chk("t5_oor_write_mw", m1, 0);
      access(1, 1'b0, 19'd262200, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, a1, m1);
      access(1, 1'b1, 19'd262144, 8'h5E, 1'b0, 1'b0, 8'h00, 1'b1, a1, m1);
      chk("t5_last_write_mw", m1, 1);
      access(1, 1'b0, 19'd262144, 8'h00, 1'b1, 1'b0, 8'h5E, 1'b1, a1, m1);
      idle(2);

      // 6: reset right after a read ack; p1 owned the port beforehand
      access(1, 1'b0, 19'd9, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, a1, m1);
      access(1, 1'b0, 19'd5, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, a1, m1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_no_rvalid_in_rst", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
      idle(1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_no_rvalid_after_rst", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
      @(posedge clk); #1;
      fork
         access(0, 1'b0, 19'd5, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, a0, m0);
         access(1, 1'b0, 19'd7, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, a1, m1);
      join
      chk("t6_idle_rules_p0_first", a1, a0 + 1);
      idle(3);
      chk("sb_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
